// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter sharing the register file
// write port among `clients` valid/ready requesters, one write per cycle.
// Build option RF_ARB_CLEAR_EN adds a clear walk that zero-fills all
// `size` entries and locks out clients while it runs.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/ready     per-client handshake (ready is one-hot or zero)
//   req_index/data      per-client packed index and data
//   writeEn/Index/Data  registered register-file write port
//   clear_start         pulse requesting a zero-fill
//   clear_busy          clear walk in progress
module regfile_write_arbiter #(
    parameter int clients = 4,
    parameter int width   = 32,
    parameter int n       = 5,
    parameter int size    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [clients-1:0]       req_valid,
    output logic [clients-1:0]       req_ready,
    input  logic [clients*n-1:0]     req_index,
    input  logic [clients*width-1:0] req_data,
    output logic                     writeEn,
    output logic [n-1:0]             writeIndex,
    output logic [width-1:0]         writeData,
    input  logic                     clear_start,
    output logic                     clear_busy
);

    localparam int PW = (clients > 1) ? $clog2(clients) : 1;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    grantIdx;
    logic [PW-1:0]    nextPtr;
    logic             anyGrant;
    logic             canGrant;
    logic             inClear;
    logic [n-1:0]     selIndex;
    logic [width-1:0] selData;

`ifdef RF_ARB_CLEAR_EN
    localparam int CW = $clog2(size + 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state;
    // counter holds the next index to issue; reaching size means done
    logic [CW-1:0] counter;
    logic          clearWrite;
    logic [n-1:0]  clearIndex;

    assign inClear    = (state == CLEAR);
    assign clear_busy = inClear;
    assign clearWrite = (state == IDLE) ? clear_start
                                        : (counter != CW'(size));
    assign clearIndex = (state == IDLE) ? '0 : n'(counter);
`else
    logic unusedClearStart;
    localparam int unusedSize = size;

    assign unusedClearStart = clear_start;
    assign inClear          = 1'b0;
    assign clear_busy       = 1'b0;
`endif

    assign canGrant = rst_n && !inClear;

    // Rotating priority: first look at clients at or above ptr, then
    // wrap around to the lowest-numbered valid client.
    always_comb begin
        req_ready = '0;
        anyGrant  = 1'b0;
        grantIdx  = '0;
        selIndex  = '0;
        selData   = '0;
        for (int c = 0; c < clients; c++) begin
            if (!anyGrant && canGrant && req_valid[c]
                && c >= int'(ptr)) begin
                anyGrant     = 1'b1;
                req_ready[c] = 1'b1;
                grantIdx     = PW'(c);
                selIndex     = req_index[c*n +: n];
                selData      = req_data[c*width +: width];
            end
        end
        for (int c = 0; c < clients; c++) begin
            if (!anyGrant && canGrant && req_valid[c]) begin
                anyGrant     = 1'b1;
                req_ready[c] = 1'b1;
                grantIdx     = PW'(c);
                selIndex     = req_index[c*n +: n];
                selData      = req_data[c*width +: width];
            end
        end
    end

    assign nextPtr = (int'(grantIdx) == clients - 1) ? '0
                                                     : grantIdx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr        <= '0;
            writeEn    <= 1'b0;
            writeIndex <= '0;
            writeData  <= '0;
`ifdef RF_ARB_CLEAR_EN
            state      <= IDLE;
            counter    <= '0;
`endif
        end else begin
            writeEn <= 1'b0;
            if (anyGrant) begin
                ptr        <= nextPtr;
                writeEn    <= 1'b1;
                writeIndex <= selIndex;
                writeData  <= selData;
            end
`ifdef RF_ARB_CLEAR_EN
            else if (clearWrite) begin
                writeEn    <= 1'b1;
                writeIndex <= clearIndex;
                writeData  <= '0;
            end

            unique case (state)
                IDLE: begin
                    if (clear_start) begin
                        state <= CLEAR;
                        // a same-cycle client write goes out first,
                        // so index 0 is issued one cycle later
                        counter <= anyGrant ? '0 : CW'(1);
                    end
                end
                CLEAR: begin
                    if (counter == CW'(size)) begin
                        state   <= IDLE;
                        counter <= '0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
`endif
        end
    end

endmodule
